// File: rtl/powerup_scheduler.sv
// Power-up item spawner/effect scheduler: item spawn, pickup, timed effect, respawn cooldown.
// Latency: one tick per transition, effect outputs combinational from tool; no backpressure, holds between ticks.
module powerup_scheduler #(
    parameter int EFFECT_TICKS  = 5000,
    parameter int RESPAWN_TICKS = 256
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        run,
    input  logic        hit,
    input  logic        dir_right,
    input  logic [3:0]  rand_tool,
    input  logic [9:0]  rand_x,
    input  logic [9:0]  rand_y,
    output logic        item_visible,
    output logic [9:0]  item_x,
    output logic [9:0]  item_y,
    output logic [3:0]  tool,
    output logic [10:0] ball_r,
    output logic [10:0] ball_speed,
    output logic [10:0] p1_len,
    output logic [10:0] p2_len,
    output logic [10:0] p1_speed,
    output logic [10:0] p2_speed,
    output logic [12:0] remaining
);

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, COOLDOWN} state_t;

    localparam logic [12:0] EFFECT_LOAD  = 13'(EFFECT_TICKS - 1);
    localparam logic [12:0] RESPAWN_LOAD = 13'(RESPAWN_TICKS - 1);

    state_t      state_q, state_d;
    logic        vis_q, vis_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [3:0]  tool_q, tool_d;
    logic [12:0] rem_q, rem_d;
    logic [9:0]  spawn_x, spawn_y;
    logic [3:0]  res_tool;

    // Keep the item box inside the playfield.
    always_comb begin
        spawn_x = rand_x;
        if ({1'b0, rand_x} < 11'd200)       spawn_x = 10'd200;
        else if ({1'b0, rand_x} > 11'd1080) spawn_x = 10'd1023;
        spawn_y = rand_y;
        if (rand_y < 10'd150)      spawn_y = 10'd150;
        else if (rand_y > 10'd870) spawn_y = 10'd870;
    end

    // Beneficial effects go to the last hitter, penalties to the opponent.
    always_comb begin
        res_tool = 4'd0;
        case (rand_tool)
            4'd1, 4'd4:  res_tool = rand_tool;
            4'd2, 4'd3:  res_tool = dir_right ? 4'd2  : 4'd3;
            4'd7, 4'd8:  res_tool = dir_right ? 4'd7  : 4'd8;
            4'd5, 4'd6:  res_tool = dir_right ? 4'd6  : 4'd5;
            4'd9, 4'd10: res_tool = dir_right ? 4'd10 : 4'd9;
            default:     res_tool = 4'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        vis_d   = vis_q;
        x_d     = x_q;
        y_d     = y_q;
        tool_d  = tool_q;
        rem_d   = rem_q;
        if (tick) begin
            if (!run) begin
                state_d = IDLE;
                vis_d   = 1'b0;
                tool_d  = 4'd0;
                rem_d   = 13'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        x_d     = spawn_x;
                        y_d     = spawn_y;
                        vis_d   = 1'b1;
                        state_d = ARMED;
                    end
                    ARMED: begin
                        if (hit) begin
                            vis_d  = 1'b0;
                            x_d    = spawn_x;
                            y_d    = spawn_y;
                            tool_d = res_tool;
                            if (res_tool != 4'd0) begin
                                rem_d   = EFFECT_LOAD;
                                state_d = ACTIVE;
                            end else begin
                                rem_d   = RESPAWN_LOAD;
                                state_d = COOLDOWN;
                            end
                        end
                    end
                    ACTIVE: begin
                        if (rem_q == 13'd0) begin
                            tool_d  = 4'd0;
                            rem_d   = RESPAWN_LOAD;
                            state_d = COOLDOWN;
                        end else begin
                            rem_d = rem_q - 13'd1;
                        end
                    end
                    COOLDOWN: begin
                        if (rem_q == 13'd0) begin
                            vis_d   = 1'b1;
                            state_d = ARMED;
                        end else begin
                            rem_d = rem_q - 13'd1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            vis_q   <= 1'b0;
            x_q     <= 10'd640;
            y_q     <= 10'd512;
            tool_q  <= 4'd0;
            rem_q   <= 13'd0;
        end else begin
            state_q <= state_d;
            vis_q   <= vis_d;
            x_q     <= x_d;
            y_q     <= y_d;
            tool_q  <= tool_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        ball_r     = 11'd10;
        ball_speed = 11'd1;
        p1_len     = 11'd125;
        p2_len     = 11'd125;
        p1_speed   = 11'd5;
        p2_speed   = 11'd5;
        case (tool_q)
            4'd1:    ball_r     = 11'd20;
            4'd2:    p1_len     = 11'd200;
            4'd3:    p2_len     = 11'd200;
            4'd4:    ball_speed = 11'd2;
            4'd5:    p1_len     = 11'd50;
            4'd6:    p2_len     = 11'd50;
            4'd7:    p1_speed   = 11'd10;
            4'd8:    p2_speed   = 11'd10;
            4'd9:    p1_speed   = 11'd3;
            4'd10:   p2_speed   = 11'd3;
            default: ;
        endcase
    end

    assign item_visible = vis_q;
    assign item_x       = x_q;
    assign item_y       = y_q;
    assign tool         = tool_q;
    assign remaining    = rem_q;

endmodule

// File: tb/tb_powerup_scheduler.sv
// Directed bench for powerup_scheduler with shortened effect/respawn periods.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each tick.
module tb_powerup_scheduler;

    localparam int E = 8;
    localparam int R = 4;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n  = 1'b0;
    logic        tick = 1'b0, run = 1'b0, hit = 1'b0, dir_right = 1'b0;
    logic [3:0]  rand_tool = 4'd0;
    logic [9:0]  rand_x = 10'd0, rand_y = 10'd0;
    logic        item_visible;
    logic [9:0]  item_x, item_y;
    logic [3:0]  tool;
    logic [10:0] ball_r, ball_speed, p1_len, p2_len, p1_speed, p2_speed;
    logic [12:0] remaining;

    int tests = 0;
    int fails = 0;

    powerup_scheduler #(.EFFECT_TICKS(E), .RESPAWN_TICKS(R)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .tick(tick), .run(run), .hit(hit),
        .dir_right(dir_right), .rand_tool(rand_tool), .rand_x(rand_x), .rand_y(rand_y),
        .item_visible(item_visible), .item_x(item_x), .item_y(item_y), .tool(tool),
        .ball_r(ball_r), .ball_speed(ball_speed), .p1_len(p1_len), .p2_len(p2_len),
        .p1_speed(p1_speed), .p2_speed(p2_speed), .remaining(remaining)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic       run, hit, dir;
        logic [3:0] rt;
        logic [9:0] rx, ry;
        logic       vis;
        logic [3:0] tool;
        logic [9:0] x, y;
        int         rem;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected effect outputs derived from the effect table for a given tool code.
    task automatic chk_all(input string name, input int vis, input int t, input int x, input int y, input int rem);
        chk({name, ".vis"}, int'(item_visible), vis);
        chk({name, ".tool"}, int'(tool), t);
        chk({name, ".x"}, int'(item_x), x);
        chk({name, ".y"}, int'(item_y), y);
        chk({name, ".rem"}, int'(remaining), rem);
        chk({name, ".ball_r"}, int'(ball_r), (t == 1) ? 20 : 10);
        chk({name, ".ball_speed"}, int'(ball_speed), (t == 4) ? 2 : 1);
        chk({name, ".p1_len"}, int'(p1_len), (t == 2) ? 200 : (t == 5) ? 50 : 125);
        chk({name, ".p2_len"}, int'(p2_len), (t == 3) ? 200 : (t == 6) ? 50 : 125);
        chk({name, ".p1_speed"}, int'(p1_speed), (t == 7) ? 10 : (t == 9) ? 3 : 5);
        chk({name, ".p2_speed"}, int'(p2_speed), (t == 8) ? 10 : (t == 10) ? 3 : 5);
    endtask

    task automatic step();
        tick = 1'b1;
        @(negedge CLOCK_50);
        tick = 1'b0;
    endtask

    initial begin
        int rt_tab[16]  = '{1, 4, 2, 2, 3, 3, 7, 8, 5, 5, 6, 9, 10, 0, 11, 15};
        int dir_tab[16] = '{0, 1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1,  1, 0,  1};
        int exp_tab[16] = '{1, 4, 2, 3, 2, 3, 7, 8, 6, 5, 5, 9, 10, 0, 0,  0};

        //             run hit dir rt    rx     ry     vis tool  x      y     rem
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd0,  10'd500, 10'd400, 1'b1, 4'd0, 10'd500, 10'd400, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'd2,  10'd10,  10'd10,  1'b1, 4'd0, 10'd500, 10'd400, 0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'd2,  10'd300, 10'd300, 1'b0, 4'd3, 10'd300, 10'd300, E-1};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 4'd5,  10'd900, 10'd900, 1'b0, 4'd3, 10'd300, 10'd300, E-2};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 4'd5,  10'd900, 10'd900, 1'b0, 4'd0, 10'd300, 10'd300, 0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 4'd0,  10'd5,   10'd1000,1'b1, 4'd0, 10'd200, 10'd870, 0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 4'd13, 10'd1023,10'd0,   1'b0, 4'd0, 10'd1023,10'd150, R-1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'd1,  10'd0,   10'd0,   1'b0, 4'd0, 10'd1023,10'd150, R-2};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'd1,  10'd0,   10'd0,   1'b0, 4'd0, 10'd1023,10'd150, R-3};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 4'd1,  10'd0,   10'd0,   1'b0, 4'd0, 10'd1023,10'd150, 0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 4'd1,  10'd0,   10'd0,   1'b1, 4'd0, 10'd1023,10'd150, 0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 4'd1,  10'd640, 10'd512, 1'b0, 4'd1, 10'd640, 10'd512, E-1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 4'd0,  10'd0,   10'd0,   1'b0, 4'd0, 10'd640, 10'd512, 0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 4'd0,  10'd199, 10'd149, 1'b1, 4'd0, 10'd200, 10'd150, 0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 4'd8,  10'd700, 10'd871, 1'b0, 4'd8, 10'd700, 10'd870, E-1};

        // Reset holds even while ticks arrive.
        tick = 1'b1; run = 1'b1; rand_x = 10'd300;
        repeat (3) @(negedge CLOCK_50);
        chk_all("reset", 0, 0, 640, 512, 0);
        tick = 1'b0; run = 1'b0;
        reset_n = 1'b1;
        @(negedge CLOCK_50);

        for (int i = 0; i < 15; i++) begin
            run = vecs[i].run; hit = vecs[i].hit; dir_right = vecs[i].dir;
            rand_tool = vecs[i].rt; rand_x = vecs[i].rx; rand_y = vecs[i].ry;
            step();
            chk_all($sformatf("vec%0d", i), int'(vecs[i].vis), int'(vecs[i].tool),
                    int'(vecs[i].x), int'(vecs[i].y), vecs[i].rem);
        end

        // Full effect lifetime then respawn.
        run = 1'b0; hit = 1'b0; step();
        run = 1'b1; rand_x = 10'd400; rand_y = 10'd300; step();
        hit = 1'b1; rand_tool = 4'd9; dir_right = 1'b1; step();
        chk_all("life.grant", 0, 10, 400, 300, E-1);
        hit = 1'b0;
        repeat (E - 1) step();
        chk_all("life.last", 0, 10, 400, 300, 0);
        step();
        chk_all("life.expire", 0, 0, 400, 300, R-1);
        repeat (R - 1) step();
        chk_all("life.cool0", 0, 0, 400, 300, 0);
        step();
        chk_all("life.respawn", 1, 0, 400, 300, 0);

        // Tool resolution for every code class and direction.
        for (int k = 0; k < 16; k++) begin
            run = 1'b0; hit = 1'b0; step();
            run = 1'b1; rand_x = 10'd600; rand_y = 10'd500; step();
            hit = 1'b1; rand_tool = 4'(rt_tab[k]); dir_right = 1'(dir_tab[k]); step();
            chk_all($sformatf("res%0d_d%0d", rt_tab[k], dir_tab[k]), 0, exp_tab[k], 600, 500,
                    (exp_tab[k] == 0) ? R-1 : E-1);
        end

        // Global speed effect: hits ignored, then run drop cancels it.
        hit = 1'b0; run = 1'b0; step();
        run = 1'b1; rand_x = 10'd700; rand_y = 10'd600; step();
        hit = 1'b1; rand_tool = 4'd4; step();
        chk_all("spd.grant", 0, 4, 700, 600, E-1);
        rand_tool = 4'd1; rand_x = 10'd250; rand_y = 10'd250;
        repeat (3) step();
        chk_all("spd.hits", 0, 4, 700, 600, E-4);
        run = 1'b0; step();
        chk_all("spd.cancel", 0, 0, 700, 600, 0);

        // No tick: nothing moves for 100 cycles, regardless of hit/run.
        run = 1'b1; rand_x = 10'd800; rand_y = 10'd800; step();
        hit = 1'b1; rand_tool = 4'd2; rand_x = 10'd300; rand_y = 10'd300;
        repeat (100) @(negedge CLOCK_50);
        chk_all("notick.armed", 1, 0, 800, 800, 0);
        run = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        chk_all("notick.run0", 1, 0, 800, 800, 0);

        // Asynchronous reset mid-effect.
        run = 1'b1; step();
        chk_all("pre_arst", 0, 2, 300, 300, E-1);
        #3 reset_n = 1'b0;
        #1 chk_all("arst", 0, 0, 640, 512, 0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/powerup_scheduler.md
POWERUP_SCHEDULER -- requirements
Module: powerup_scheduler

Interface
REQ-001 SHALL have parameter EFFECT_TICKS, default 5000: number of game ticks a granted effect lasts.
REQ-002 SHALL have parameter RESPAWN_TICKS, default 256: number of game ticks between effect expiry and item reappearance.
REQ-003 SHALL have port CLOCK_50, input, 1 bit: the single clock; every flop is clocked on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port tick, input, 1 bit: one-cycle game-step strobe; all state advances happen only on cycles with tick=1.
REQ-006 SHALL have port run, input, 1 bit: game running; 0 means hold in IDLE.
REQ-007 SHALL have port hit, input, 1 bit: ball overlaps the item box; a level signal, sampled on tick.
REQ-008 SHALL have port dir_right, input, 1 bit: 1 means the ball is moving right, i.e. P1 was the last hitter.
REQ-009 SHALL have ports rand_tool, rand_x and rand_y, inputs, 4, 10 and 10 bits: free-running random sources.
REQ-010 SHALL have ports item_visible, item_x and item_y, outputs, 1, 10 and 10 bits: item drawing and collision position.
REQ-011 SHALL have port tool, output, 4 bits: the active effect code, 0 meaning none.
REQ-012 SHALL have port ball_r, output, 11 bits: ball radius.
REQ-013 SHALL have port ball_speed, output, 11 bits: ball speed.
REQ-014 SHALL have ports p1_len and p2_len, outputs, 11 bits each: paddle lengths.
REQ-015 SHALL have ports p1_speed and p2_speed, outputs, 11 bits each: paddle speeds.
REQ-016 SHALL have port remaining, output, 13 bits: ticks left in the current ACTIVE or COOLDOWN period.

Function
REQ-017 SHALL implement four states: IDLE, ARMED, ACTIVE and COOLDOWN.
REQ-018 SHALL update all state, counter, item and tool registers only on cycles with tick=1; they are held otherwise.
REQ-019 SHALL, on any tick with run=0, go to IDLE with tool=0, item_visible=0 and remaining=0; this takes priority over all other transitions.
REQ-020 SHALL, in IDLE on a tick with run=1, latch item_x=rand_x and item_y=rand_y, set item_visible=1 and go to ARMED.
REQ-021 SHALL, in ARMED on a tick with hit=1: set item_visible=0, set tool to the resolved code (REQ-022), load remaining=EFFECT_TICKS-1, go to ACTIVE, and latch a new item_x/item_y from rand_x/rand_y for the next spawn.
REQ-022 SHALL resolve the tool code from rand_tool as follows:
- 1 and 4: global effects, passed through unchanged.
- 2 (grow) and 7 (fast): beneficial; go to the last hitter. P1 gets 2/7 when dir_right=1; P2 gets 3/8 when dir_right=0.
- 3 and 8: treated as 2 and 7 respectively, then redirected by the same rule.
- 5 (shrink) and 9 (slow): penalties; go to the opponent. P2 gets 6/10 when dir_right=1; P1 gets 5/9 when dir_right=0.
- 6 and 10: treated as 5 and 9 respectively, then redirected by the same rule.
- 0 and 11-15: no effect. tool stays 0, remaining is loaded with RESPAWN_TICKS-1 and the state goes directly to COOLDOWN.
REQ-023 SHALL, in ACTIVE, decrement remaining on each tick; on the tick where remaining=0 it sets tool=0, loads remaining=RESPAWN_TICKS-1 and goes to COOLDOWN.
REQ-024 SHALL ignore hit in ACTIVE and in COOLDOWN.
REQ-025 SHALL, in COOLDOWN, decrement remaining on each tick; on the tick where remaining=0 it sets item_visible=1 and goes to ARMED.
REQ-026 SHALL drive the effect outputs combinationally from tool, against these defaults: ball_r=10, ball_speed=1, p1_len=p2_len=125, p1_speed=p2_speed=5.
REQ-027 SHALL apply these overrides per tool code, one field each:
- 1: ball_r=20.
- 2: p1_len=200.
- 3: p2_len=200.
- 4: ball_speed=2.
- 5: p1_len=50.
- 6: p2_len=50.
- 7: p1_speed=10.
- 8: p2_speed=10.
- 9: p1_speed=3.
- 10: p2_speed=3.
REQ-028 SHALL restrict item_x to the range 200..1080 by clamping rand_x at latch time, and restrict item_y to 150..870 by clamping rand_y.
REQ-029 SHALL make run=0 and hit=1 in the same tick resolve to IDLE, with no effect granted.
REQ-030 SHALL keep remaining from wrapping; its decrement happens only while it is nonzero.

Reset
REQ-031 SHALL, while reset_n=0, asynchronously force: state=IDLE, tool=0, item_visible=0, item_x=640, item_y=512, remaining=0; the effect outputs therefore take their default values.
REQ-032 SHALL, after reset_n deasserts, take its first transition on the first tick.

Verification
REQ-033 SHALL be verified by: reset, run=1, one tick with rand_x=500, rand_y=400 -> state ARMED, item_visible=1, item at (500,400).
REQ-034 SHALL be verified by: ARMED, hit=1, rand_tool=2, dir_right=0 -> tool=3, p2_len=200, p1_len=125, remaining=EFFECT_TICKS-1.
REQ-035 SHALL be verified by: ARMED, hit=1, rand_tool=9, dir_right=1 -> tool=10, p2_speed=3; after EFFECT_TICKS ticks -> tool=0 and COOLDOWN; after RESPAWN_TICKS more ticks -> item_visible=1.
REQ-036 SHALL be verified by: ARMED, hit=1, rand_tool=13 -> tool=0, COOLDOWN, remaining=RESPAWN_TICKS-1.
REQ-037 SHALL be verified by: ACTIVE with tool=4, run=0 for one tick -> IDLE, tool=0, ball_speed=1; hit pulses in ACTIVE produce no change.
REQ-038 SHALL be verified by: rand_x=5, rand_y=1000 at spawn -> item at (200,870); tick held at 0 for 100 cycles with hit=1 -> no state change.
